// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
package mem_arb_pkg;

  localparam int unsigned DefAddrW = 9;
  localparam int unsigned DefDataW = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StWait = 2'd2,
    StResp = 2'd3
  } arb_state_e;

  typedef enum logic {
    OwnCpu = 1'b0,
    OwnDbg = 1'b1
  } owner_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker; lock masks out the CPU request.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last,
  input  logic       lock,
  output logic       gnt_valid,
  output owner_e     gnt_id
);

  logic [1:0] elig;

  always_comb begin
    elig      = lock ? {req[1], 1'b0} : req;
    gnt_valid = |elig;
    gnt_id    = OwnCpu;
    if (elig == 2'b11) begin
      gnt_id = (last == OwnCpu) ? OwnDbg : OwnCpu;
    end else if (elig[1]) begin
      gnt_id = OwnDbg;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the CPU memory stage and a debug port.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  input  logic              dbg_lock,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic              op_we_q, op_we_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic   gnt_valid;
  owner_e gnt_id;

  rr_pick2 u_pick (
    .req      ({dbg_req, cpu_req}),
    .last     (last_q),
    .lock     (dbg_lock),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    op_we_d     = op_we_q;
    cnt_d       = cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          state_d = StAcc;
          owner_d = gnt_id;
          last_d  = gnt_id;
          if (gnt_id == OwnDbg) begin
            ram_addr_d  = dbg_addr;
            ram_wdata_d = dbg_wdata;
            op_we_d     = dbg_we;
          end else begin
            ram_addr_d  = cpu_addr;
            ram_wdata_d = cpu_wdata;
            op_we_d     = cpu_we;
          end
          ram_we_d = op_we_d;
        end
      end
      StAcc: begin
        cnt_d   = 2'd0;
        state_d = op_we_q ? StResp : StWait;
      end
      StWait: begin
        // RAM latched the address on the ACC->WAIT edge; data is valid in the last WAIT cycle.
        if (cnt_q == 2'(RD_LAT - 1)) begin
          state_d = StResp;
          if (owner_q == OwnDbg) begin
            dbg_rdata_d = ram_rdata;
          end else begin
            cpu_rdata_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= OwnCpu;
      last_q      <= OwnDbg;
      op_we_q     <= 1'b0;
      cnt_q       <= 2'd0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      op_we_q     <= op_we_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign cpu_ack   = (state_q == StResp) && (owner_q == OwnCpu);
  assign dbg_ack   = (state_q == StResp) && (owner_q == OwnDbg);
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: RD_LAT=1 instance plus an RD_LAT=3 instance.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // RD_LAT=1 instance
  logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_ack, dbg_lock;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;

  // RD_LAT=3 instance
  logic          l3_cpu_req, l3_cpu_we, l3_cpu_ack, l3_cpu_stall;
  logic [AW-1:0] l3_cpu_addr;
  logic [DW-1:0] l3_cpu_wdata, l3_cpu_rdata;
  logic          l3_dbg_req, l3_dbg_we, l3_dbg_ack, l3_dbg_lock;
  logic [AW-1:0] l3_dbg_addr;
  logic [DW-1:0] l3_dbg_wdata, l3_dbg_rdata;
  logic [AW-1:0] l3_ram_addr;
  logic          l3_ram_we;
  logic [DW-1:0] l3_ram_wdata, l3_ram_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack  (cpu_ack),
    .cpu_stall(cpu_stall),
    .dbg_req  (dbg_req),
    .dbg_we   (dbg_we),
    .dbg_addr (dbg_addr),
    .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata),
    .dbg_ack  (dbg_ack),
    .dbg_lock (dbg_lock),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut3 (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (l3_cpu_req),
    .cpu_we   (l3_cpu_we),
    .cpu_addr (l3_cpu_addr),
    .cpu_wdata(l3_cpu_wdata),
    .cpu_rdata(l3_cpu_rdata),
    .cpu_ack  (l3_cpu_ack),
    .cpu_stall(l3_cpu_stall),
    .dbg_req  (l3_dbg_req),
    .dbg_we   (l3_dbg_we),
    .dbg_addr (l3_dbg_addr),
    .dbg_wdata(l3_dbg_wdata),
    .dbg_rdata(l3_dbg_rdata),
    .dbg_ack  (l3_dbg_ack),
    .dbg_lock (l3_dbg_lock),
    .ram_addr (l3_ram_addr),
    .ram_we   (l3_ram_we),
    .ram_wdata(l3_ram_wdata),
    .ram_rdata(l3_ram_rdata)
  );

  // Synchronous RAM models: address latched on the edge, data after RD_LAT edges.
  logic [DW-1:0] mem1 [2**AW];
  logic [DW-1:0] mem3 [2**AW];
  logic [DW-1:0] rd1;
  logic [DW-1:0] p1, p2, p3;

  always @(posedge clk) begin
    if (ram_we) mem1[ram_addr] <= ram_wdata;
    rd1 <= mem1[ram_addr];
    if (l3_ram_we) mem3[l3_ram_addr] <= l3_ram_wdata;
    p1 <= mem3[l3_ram_addr];
    p2 <= p1;
    p3 <= p2;
  end
  assign ram_rdata    = rd1;
  assign l3_ram_rdata = p3;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Counts negedges from now until the selected ack is seen (0=cpu, 1=dbg), bounded.
  task automatic wait_ack(input string tag, input int port, input int exp_cyc);
    int   cyc = 0;
    logic a;
    do begin
      tick();
      cyc++;
      a = (port == 0) ? cpu_ack : dbg_ack;
    end while (!a && cyc < 20);
    check(tag, 32'(cyc), 32'(exp_cyc));
  endtask

  int   n_acks, cyc, stall_drop, early;
  logic got_id [4];
  int   got_cyc [4];
  logic exp_rr [4];
  logic exp_lk [4];
  int   exp_cyc [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_rr  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_lk  = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_cyc = '{3, 7, 11, 15};
    for (int i = 0; i < 2**AW; i++) begin
      mem1[i] = '0;
      mem3[i] = '0;
    end
    mem3[9'h1FF] = 32'h1234_5678;
    mem3[9'h000] = 32'hBAD0_0000;

    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;
    l3_cpu_req = 0; l3_cpu_we = 0; l3_cpu_addr = '0; l3_cpu_wdata = '0;
    l3_dbg_req = 0; l3_dbg_we = 0; l3_dbg_addr = '0; l3_dbg_wdata = '0; l3_dbg_lock = 0;
    reset = 1;

    // Reset state
    repeat (2) tick();
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dbg_rdata", dbg_rdata, 32'd0);
    check("rst_stall_idle", 32'(cpu_stall), 32'd0);
    cpu_req = 1;
    #1;
    check("rst_stall_follows_req", 32'(cpu_stall), 32'd1);
    cpu_req = 0;
    tick();
    reset = 0;
    tick();

    // CPU write 0x055 <- 0x23
    cpu_req = 1; cpu_we = 1; cpu_addr = 9'h055; cpu_wdata = 32'h0000_0023;
    #1;
    check("wr_stall_pre", 32'(cpu_stall), 32'd1);
    tick();
    check("wr_ram_we", 32'(ram_we), 32'd1);
    check("wr_ram_addr", 32'(ram_addr), 32'h055);
    check("wr_ram_wdata", ram_wdata, 32'h0000_0023);
    check("wr_ack_early", 32'(cpu_ack), 32'd0);
    check("wr_stall_acc", 32'(cpu_stall), 32'd1);
    tick();
    check("wr_ack", 32'(cpu_ack), 32'd1);
    check("wr_ram_we_resp", 32'(ram_we), 32'd0);
    check("wr_stall_ack", 32'(cpu_stall), 32'd0);
    check("wr_dbg_ack", 32'(dbg_ack), 32'd0);
    cpu_req = 0; cpu_we = 0;
    tick();
    check("wr_ack_pulse", 32'(cpu_ack), 32'd0);

    // CPU read 0x055, RD_LAT=1
    cpu_req = 1; cpu_addr = 9'h055;
    tick();
    check("rd_ack_acc", 32'(cpu_ack), 32'd0);
    check("rd_ram_we", 32'(ram_we), 32'd0);
    tick();
    check("rd_ack_wait", 32'(cpu_ack), 32'd0);
    check("rd_stall_wait", 32'(cpu_stall), 32'd1);
    tick();
    check("rd_ack", 32'(cpu_ack), 32'd1);
    check("rd_rdata", cpu_rdata, 32'h0000_0023);
    check("rd_dbg_ack", 32'(dbg_ack), 32'd0);
    cpu_req = 0;
    tick();
    check("rd_ack_pulse", 32'(cpu_ack), 32'd0);
    check("rd_rdata_held", cpu_rdata, 32'h0000_0023);

    // DBG write 0x0AA <- 0xDEADBEEF
    dbg_req = 1; dbg_we = 1; dbg_addr = 9'h0AA; dbg_wdata = 32'hDEAD_BEEF;
    wait_ack("dbg_wr_latency", 1, 2);
    check("dbg_wr_cpu_ack", 32'(cpu_ack), 32'd0);
    dbg_req = 0; dbg_we = 0;
    check("dbg_wr_cpu_rdata_kept", cpu_rdata, 32'h0000_0023);
    check("dbg_wr_dbg_rdata_kept", dbg_rdata, 32'd0);
    tick();

    // Both requesting reads: round-robin
    cpu_addr = 9'h055; dbg_addr = 9'h0AA;
    cpu_req = 1; dbg_req = 1;
    n_acks = 0; cyc = 0;
    for (int i = 0; i < 4; i++) begin got_id[i] = 1'bx; got_cyc[i] = -1; end
    while (n_acks < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (cpu_ack || dbg_ack) begin
        got_id[n_acks]  = dbg_ack;
        got_cyc[n_acks] = cyc;
        if (cpu_ack && dbg_ack) check("rr_both_ack", 32'd1, 32'd0);
        if (dbg_ack) check("rr_dbg_rdata", dbg_rdata, 32'hDEAD_BEEF);
        else         check("rr_cpu_rdata", cpu_rdata, 32'h0000_0023);
        n_acks++;
      end
    end
    cpu_req = 0; dbg_req = 0;
    check("rr_count", 32'(n_acks), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_owner%0d", i), 32'(got_id[i]), 32'(exp_rr[i]));
      check($sformatf("rr_cycle%0d", i), 32'(got_cyc[i]), 32'(exp_cyc[i]));
    end
    tick();

    // Lock: only DBG for 3 accesses, then release and CPU wins
    dbg_lock = 1; cpu_req = 1; dbg_req = 1;
    n_acks = 0; cyc = 0; stall_drop = 0;
    for (int i = 0; i < 4; i++) begin got_id[i] = 1'bx; got_cyc[i] = -1; end
    while (n_acks < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (n_acks < 3 && !cpu_stall) stall_drop++;
      if (cpu_ack || dbg_ack) begin
        got_id[n_acks]  = dbg_ack;
        got_cyc[n_acks] = cyc;
        n_acks++;
        if (n_acks == 3) dbg_lock = 0;
      end
    end
    cpu_req = 0; dbg_req = 0; dbg_lock = 0;
    check("lk_count", 32'(n_acks), 32'd4);
    check("lk_stall_held", 32'(stall_drop), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lk_owner%0d", i), 32'(got_id[i]), 32'(exp_lk[i]));
      check($sformatf("lk_cycle%0d", i), 32'(got_cyc[i]), 32'(exp_cyc[i]));
    end
    tick();

    // Reset during WAIT of a DBG read
    dbg_req = 1; dbg_we = 0; dbg_addr = 9'h0AA;
    tick();
    tick();
    reset = 1; dbg_req = 0;
    tick();
    check("rstw_dbg_ack", 32'(dbg_ack), 32'd0);
    check("rstw_dbg_rdata", dbg_rdata, 32'd0);
    check("rstw_cpu_rdata", cpu_rdata, 32'd0);
    check("rstw_ram_we", 32'(ram_we), 32'd0);
    check("rstw_state", 32'(u_dut.state_q), 32'(StIdle));
    reset = 0;
    tick();
    check("rstw_no_late_ack", 32'(dbg_ack), 32'd0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h055;
    wait_ack("rstw_cpu_rd_latency", 0, 3);
    check("rstw_cpu_rd_rdata", cpu_rdata, 32'h0000_0023);
    cpu_req = 0;
    tick();

    // RD_LAT=3: debug read of the top address
    l3_dbg_req = 1; l3_dbg_we = 0; l3_dbg_addr = 9'h1FF;
    tick();
    check("l3_ram_addr", 32'(l3_ram_addr), 32'h1FF);
    early = 0;
    if (l3_dbg_ack) early++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (l3_dbg_ack) early++;
    end
    check("l3_no_early_ack", 32'(early), 32'd0);
    tick();
    check("l3_ack", 32'(l3_dbg_ack), 32'd1);
    check("l3_rdata", l3_dbg_rdata, 32'h1234_5678);
    check("l3_cpu_ack", 32'(l3_cpu_ack), 32'd0);
    l3_dbg_req = 0;
    tick();
    check("l3_ack_pulse", 32'(l3_dbg_ack), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
